piso: RTL and testbench

- Parallel-in, serial-out driver for a daisy chain of SN74HC595 shift/latch registers on the CNC3 board (board digital outputs).
- It is the output-side counterpart of the sipo input reader.
- It accepts a WIDTH-bit word with a valid/ready handshake, shifts the word MSB-first on sdo/sclk at a divided rate, then pulses rclk to transfer the word to the 595 output latches.
- oe_n keeps the 595 outputs disabled until the first word has been latched.

---
 rtl/cnc3_pkg.sv | 16 +
 rtl/clk_div_tick.sv | 29 ++
 rtl/piso.sv | 105 ++++++++++
 tb/tb_piso.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnc3_pkg.sv
// Shared types and helpers for the CNC3 board I/O shift-register drivers (piso, sipo).
package cnc3_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } piso_state_t;

  // Width of a counter that must hold the values 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_tick.sv
// Terminal-count strobe: counts enabled clk cycles 0..CLK_DIV-1 and pulses tick on the last one.
module clk_div_tick
  import cnc3_pkg::*;
#(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int DW = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div;

  // Combinational so the consuming FSM changes state on the same edge the phase ends.
  assign tick = en && (div == LAST);

  always_ff @(posedge clk) begin
    if (clr) begin
      div <= '0;
    end else if (en) begin
      div <= tick ? '0 : div + DW'(1);
    end
  end

endmodule

// File: rtl/piso.sv
// Parallel-in serial-out driver for a daisy chain of 74HC595 output latches (MSB first, then RCLK).
module piso
  import cnc3_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int CLK_DIV = 10
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [WIDTH-1:0] data,
  input  logic             valid,
  output logic             ready,
  output logic             done,
  output logic             sdo,
  output logic             sclk,
  output logic             rclk,
  output logic             oe_n
);

  localparam int BW = cnt_width(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  piso_state_t      state;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic             tick;
  logic             accept;

  // Handshake: a word is taken on any clk edge where valid && ready; ready is high only in
  // IDLE, valid is ignored otherwise, and data is sampled only on that accepting edge.
  assign accept = valid && ready;

  clk_div_tick #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk (clk),
    .clr (aclr || accept),
    .en  (state != IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (aclr) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      ready   <= 1'b0;
      done    <= 1'b0;
      sdo     <= 1'b0;
      sclk    <= 1'b0;
      rclk    <= 1'b0;
      oe_n    <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          sclk <= 1'b0;
          rclk <= 1'b0;
          if (accept) begin
            shreg   <= data;
            bit_cnt <= '0;
            ready   <= 1'b0;
            sdo     <= data[WIDTH-1];
            state   <= SHIFT_LO;
          end else begin
            ready <= 1'b1;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            sclk  <= 1'b1;
            state <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + BW'(1);
            sclk    <= 1'b0;
            if (bit_cnt == LAST_BIT) begin
              rclk  <= 1'b1;
              state <= LATCH;
            end else begin
              // Next bit goes out on the falling edge, giving a full phase of setup and hold.
              sdo   <= shreg[WIDTH-2];
              state <= SHIFT_LO;
            end
          end
        end
        LATCH: begin
          if (tick) begin
            rclk  <= 1'b0;
            oe_n  <= 1'b0;
            done  <= 1'b1;
            ready <= 1'b1;
            sdo   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso.sv
// Bench for piso: 16-bit chain of two 595 models at CLK_DIV=10, plus an 8-bit single-595 instance at CLK_DIV=1.
module tb_piso;

  localparam int W  = 16;
  localparam int C  = 10;
  localparam int BW = 8;
  localparam int BC = 1;
  localparam int LAT_A = 2 * C * W + C;
  localparam int LAT_B = 2 * BC * BW + BC;

  logic clk = 1'b0;
  logic aclr = 1'b1;
  always #5 clk = ~clk;

  logic [W-1:0]  a_data = '0;
  logic          a_valid = 1'b0;
  logic          a_ready, a_done, a_sdo, a_sclk, a_rclk, a_oe_n;
  logic [BW-1:0] b_data = '0;
  logic          b_valid = 1'b0;
  logic          b_ready, b_done, b_sdo, b_sclk, b_rclk, b_oe_n;

  piso #(.WIDTH(W), .CLK_DIV(C)) dut_a (
    .clk(clk), .aclr(aclr), .data(a_data), .valid(a_valid), .ready(a_ready),
    .done(a_done), .sdo(a_sdo), .sclk(a_sclk), .rclk(a_rclk), .oe_n(a_oe_n)
  );

  piso #(.WIDTH(BW), .CLK_DIV(BC)) dut_b (
    .clk(clk), .aclr(aclr), .data(b_data), .valid(b_valid), .ready(b_ready),
    .done(b_done), .sdo(b_sdo), .sclk(b_sclk), .rclk(b_rclk), .oe_n(b_oe_n)
  );

  // 595 models: near chip's QH' feeds the far chip's SER; RCLK copies shift stages to Q.
  logic [7:0]  a_sr0 = '0, a_sr1 = '0;
  logic [W-1:0] a_q = '0;
  logic [7:0]  b_sr = '0, b_q = '0;

  always @(posedge a_sclk) begin
    a_sr0 <= {a_sr0[6:0], a_sdo};
    a_sr1 <= {a_sr1[6:0], a_sr0[7]};
  end
  always @(posedge a_rclk) a_q <= {a_sr1, a_sr0};
  always @(posedge b_sclk) b_sr <= {b_sr[6:0], b_sdo};
  always @(posedge b_rclk) b_q <= b_sr;

  // Waveform monitors, index 0 = dut_a, 1 = dut_b.
  int  since_rise[2]   = '{1000, 1000};
  int  since_change[2] = '{1000, 1000};
  int  rise_period[2]  = '{0, 0};
  int  sclk_rises[2]   = '{0, 0};
  int  rclk_rises[2]   = '{0, 0};
  int  rclk_hi[2]      = '{0, 0};
  int  rclk_w[2]       = '{0, 0};
  int  stab_viol[2]    = '{0, 0};
  int  overlap_viol[2] = '{0, 0};
  logic prev_sclk[2]   = '{1'b0, 1'b0};
  logic prev_sdo[2]    = '{1'b0, 1'b0};
  logic prev_rclk[2]   = '{1'b0, 1'b0};

  task automatic mon_step(input int i, input logic sc, input logic sd, input logic rc,
                          input logic rst, input int cdiv);
    since_rise[i]++;
    since_change[i]++;
    if (sc && rc) overlap_viol[i]++;
    if (sc && !prev_sclk[i]) begin
      if (!rst && since_change[i] < cdiv) stab_viol[i]++;
      rise_period[i] = since_rise[i];
      since_rise[i]  = 0;
      sclk_rises[i]++;
    end
    if (sd !== prev_sdo[i]) begin
      if (!rst && since_rise[i] < cdiv) stab_viol[i]++;
      since_change[i] = 0;
    end
    if (rc && !prev_rclk[i]) begin
      rclk_rises[i]++;
      rclk_hi[i] = 0;
    end
    if (rc) rclk_hi[i]++;
    if (!rc && prev_rclk[i]) rclk_w[i] = rclk_hi[i];
    prev_sclk[i] = sc;
    prev_sdo[i]  = sd;
    prev_rclk[i] = rc;
  endtask

  always @(negedge clk) begin
    mon_step(0, a_sclk, a_sdo, a_rclk, aclr, C);
    mon_step(1, b_sclk, b_sdo, b_rclk, aclr, BC);
  end

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic accept_a(input logic [W-1:0] d, input logic [W-1:0] expv);
    int t = 0;
    @(negedge clk);
    a_data  = d;
    a_valid = 1'b1;
    while (!a_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready", a_ready, 1);
    @(posedge clk);
    exp_q.push_back(expv);
  endtask

  // Counts clk edges from the accepting edge until done is seen; optionally pokes a busy valid.
  task automatic wait_done(input logic keep, input logic [W-1:0] next_data, input int poke_at,
                           output int lat, output int busy, output logic oe_pre);
    int  n = 0;
    bit  seen = 0;
    busy   = 0;
    oe_pre = 1'bx;
    while (n < 2000) begin
      @(negedge clk);
      if (n == 0) begin
        a_valid = keep;
        a_data  = next_data;
      end
      if (a_done) begin
        seen = 1;
        break;
      end
      if (a_ready) busy++;
      oe_pre = a_oe_n;
      if (poke_at > 0 && n == poke_at) begin
        a_data  = 16'hDEAD;
        a_valid = 1'b1;
      end
      if (poke_at > 0 && n == poke_at + 1) a_valid = keep;
      @(posedge clk);
      n++;
    end
    check("done_seen", seen, 1);
    lat = n;
    #1;
  endtask

  task automatic finish_checks(input int r0, input int p0, input int lat, input int busy);
    check("latency", lat, LAT_A);
    check("sclk_rises", sclk_rises[0] - r0, W);
    check("rclk_pulses", rclk_rises[0] - p0, 1);
    check("rclk_width", rclk_w[0], C);
    check("sclk_period", rise_period[0], 2 * C);
    check("latched", a_q, exp_q.pop_front());
    check("ready_busy", busy, 0);
    check("oe_n_done", a_oe_n, 0);
    check("done_ready", a_ready, 1);
  endtask

  task automatic transfer_a(input logic [W-1:0] d, input logic [W-1:0] expv, input int poke_at);
    int r0, p0, lat, busy;
    logic oe_pre;
    r0 = sclk_rises[0];
    p0 = rclk_rises[0];
    accept_a(d, expv);
    wait_done(1'b0, ~d, poke_at, lat, busy, oe_pre);
    finish_checks(r0, p0, lat, busy);
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic [W-1:0] exp_latched;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int r0, p0, r1, p1, lat, busy, t, n;
    logic oe_pre;
    logic [W-1:0] d;
    bit seen;

    vecs[0] = '{16'h0000, 16'h0000};
    vecs[1] = '{16'hFFFF, 16'hFFFF};
    vecs[2] = '{16'h8000, 16'h8000};
    vecs[3] = '{16'h0001, 16'h0001};
    vecs[4] = '{16'h7FFE, 16'h7FFE};
    vecs[5] = '{16'hC3A5, 16'hC3A5};

    // Test 1: reset values, first word.
    repeat (10) @(negedge clk);
    check("rst_ready", a_ready, 0);
    check("rst_done", a_done, 0);
    check("rst_sdo", a_sdo, 0);
    check("rst_sclk", a_sclk, 0);
    check("rst_rclk", a_rclk, 0);
    check("rst_oe_n", a_oe_n, 1);
    aclr = 1'b0;
    @(negedge clk);
    check("ready_after_rst", a_ready, 1);
    r0 = sclk_rises[0];
    p0 = rclk_rises[0];
    accept_a(16'h1234, 16'h1234);
    wait_done(1'b0, 16'hEDCB, 0, lat, busy, oe_pre);
    check("oe_n_before_done", oe_pre, 1);
    finish_checks(r0, p0, lat, busy);

    // Test 2: back-to-back, second word accepted on the done cycle.
    r0 = sclk_rises[0];
    p0 = rclk_rises[0];
    accept_a(16'h55AA, 16'h55AA);
    wait_done(1'b1, 16'hFFFF, 0, lat, busy, oe_pre);
    finish_checks(r0, p0, lat, busy);
    @(posedge clk);
    exp_q.push_back(16'hFFFF);
    r1 = sclk_rises[0];
    p1 = rclk_rises[0];
    wait_done(1'b0, 16'h0000, 0, lat, busy, oe_pre);
    finish_checks(r1, p1, lat, busy);
    check("b2b_rclk_total", rclk_rises[0] - p0, 2);

    // Test 3: valid pulsed with another word while busy.
    transfer_a(16'h0F0F, 16'h0F0F, 50);

    // Test 4: reset in the middle of bit 7.
    transfer_a(16'h1234, 16'h1234, 0);
    p0 = rclk_rises[0];
    accept_a(16'hA5A5, 16'hA5A5);
    void'(exp_q.pop_back());
    @(negedge clk);
    a_valid = 1'b0;
    repeat (144) @(posedge clk);
    @(negedge clk);
    aclr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_sclk", a_sclk, 0);
    check("midrst_sdo", a_sdo, 0);
    check("midrst_ready", a_ready, 0);
    check("midrst_rclk", a_rclk, 0);
    check("midrst_oe_n", a_oe_n, 1);
    check("midrst_done", a_done, 0);
    aclr = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", a_ready, 1);
    #1;
    check("midrst_no_latch", rclk_rises[0] - p0, 0);
    check("midrst_q_kept", a_q, 16'h1234);

    // Table-driven words.
    for (int i = 0; i < 6; i++) transfer_a(vecs[i].data, vecs[i].exp_latched, 0);

    // Random words with random idle gaps, checked against the chain model.
    for (int i = 0; i < 12; i++) begin
      d = W'($urandom_range(0, 16'hFFFF));
      repeat ($urandom_range(0, 4)) @(negedge clk);
      transfer_a(d, d, (i % 3 == 0) ? int'($urandom_range(1, 300)) : 0);
    end

    // Test 5: WIDTH=8, CLK_DIV=1 instance.
    r0 = sclk_rises[1];
    p0 = rclk_rises[1];
    @(negedge clk);
    b_data  = 8'h81;
    b_valid = 1'b1;
    t = 0;
    while (!b_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("b_accept_ready", b_ready, 1);
    @(posedge clk);
    n = 0;
    seen = 0;
    while (n < 200) begin
      @(negedge clk);
      if (n == 0) begin
        b_valid = 1'b0;
        b_data  = 8'h00;
      end
      if (b_done) begin
        seen = 1;
        break;
      end
      @(posedge clk);
      n++;
    end
    #1;
    check("b_done_seen", seen, 1);
    check("b_latency", n, LAT_B);
    check("b_latched", b_q, 8'h81);
    check("b_sclk_rises", sclk_rises[1] - r0, BW);
    check("b_sclk_period", rise_period[1], 2 * BC);
    check("b_rclk_pulses", rclk_rises[1] - p0, 1);
    check("b_rclk_width", rclk_w[1], BC);
    check("b_oe_n_done", b_oe_n, 0);

    // Waveform rules over the whole run.
    repeat (3) @(negedge clk);
    check("a_sdo_stability", stab_viol[0], 0);
    check("b_sdo_stability", stab_viol[1], 0);
    check("a_sclk_rclk_overlap", overlap_viol[0], 0);
    check("b_sclk_rclk_overlap", overlap_viol[1], 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
